demux_scanner: RTL and testbench
================================

# demux_scanner

Sequencer that sits directly upstream of the 1-to-8 `Demux` and drives its `Select`, `Enable` and `DIn` inputs. On a `Start` pulse it captures a channel mask, dwell count and data word, then visits each enabled channel in ascending order. For each channel it issues an address-setup cycle, an enable strobe of programmable length, and an address-hold cycle, and it pulses `Done` when the scan finishes. Outputs are registered and connect straight to the demux ports.

## Interface
- `DataWidth`, default 1: width of the data path; matches `Demux.DataWidth`.
- `DwellWidth`, default 8: width of the dwell count.
- `Clock` in 1: rising-edge clock.
- `Reset_N` in 1: reset, asynchronous, active-low.
- `Start` in 1: scan request; sampled only in IDLE.
- `Mask` in 8: bit i set means channel i is visited; captured on accepted Start.
- `Dwell` in DwellWidth: strobe length in cycles; 0 is treated as 1; captured on accepted Start.
- `DIn` in DataWidth: data routed to each channel; captured on accepted Start.
- `Select` out 3: channel address to `Demux.Select`.
- `Enable` out 1: strobe to `Demux.Enable`.
- `DOut` out DataWidth: data to `Demux.DIn`.
- `Busy` out 1: high from the cycle after an accepted Start through the DONE cycle.
- `Done` out 1: one-cycle completion pulse.
- `Stop` in 1: present only with `DEMUX_SCANNER_REPEAT_EN`.

## Operation
- **Reset values:** `Select`=0, `Enable`=0, `DOut`=all-ones, `Busy`=0, `Done`=0, state=IDLE. The capture registers are cleared.
- **States:** IDLE, SETUP, STROBE, HOLD, DONE.
- **IDLE:**
  - `Start`=1 latches `Mask`, `Dwell` (0 becomes 1) and `DIn`.
  - It then goes to SETUP with `Select` = the lowest set mask bit.
  - If `Mask`=0, it goes to DONE instead.
- **SETUP:** `Enable`=0, `Select` stable. Goes to STROBE next cycle.
- **STROBE:** `Enable`=1 for exactly D cycles, where D is the captured dwell after the 0-to-1 rule. A down-counter loads D-1 on entry. Goes to HOLD when the count reaches 0.
- **HOLD:**
  - `Enable`=0, `Select` unchanged.
  - Clear the current channel's bit in the working mask.
  - If a higher set bit remains, go to SETUP with `Select` = next set bit; otherwise go to DONE.
- **DONE:** `Done`=1 and `Busy`=1 for one cycle, then IDLE.
- **`DOut`:** equals the captured data while `Busy`=1, and all-ones in IDLE.
- **Ignored input changes:**
  - `Start` during `Busy` is ignored and not queued.
  - Changes to `Mask`, `Dwell` or `DIn` during a scan are ignored.
- **Select changes:** `Select` changes only on entry to SETUP, never while `Enable`=1.
- **Reset mid-scan:** all outputs go to their reset values immediately (asynchronously). No `Done` is generated.

## Timing
- `Start` is accepted at rising edge k. The first SETUP is at cycle k+1.
- Each visited channel takes D+2 cycles.
- With N set mask bits, `Done` is high in cycle k+1+N(D+2). `Busy` falls at edge k+2+N(D+2).
- `Mask`=0: `Done` is high in cycle k+1 with no strobes.
- A new `Start` may be asserted in the cycle `Done` is high. It is accepted on the edge after, once the block is back in IDLE.
- Dwell maximum: 2^DwellWidth-1. No wrap occurs.

## Configuration
- **`DEMUX_SCANNER_REPEAT_EN` defined:** the `Stop` input exists and the scan is continuous.
  - After HOLD of the last set channel, the working mask reloads from the captured mask and the block goes to SETUP of the lowest channel.
  - `Stop`=1 is sampled each cycle and sets a sticky flag. The current channel's HOLD then goes to DONE.
  - A `Mask`=0 capture still goes straight to DONE.
- **Undefined:** no `Stop` port; a single pass, exactly as described above.

## Test plan
- **Single channel:** reset, then `Mask`=8'h01, `Dwell`=3, `DIn`=0, `Start` at edge 1 → `Select`=0. `Enable`=0 in cycle 2, `Enable`=1 in cycles 3–5, `Enable`=0 in cycle 6, `Done`=1 in cycle 7, `Busy` low from cycle 8. Demux `O0` is low only in cycles 3–5; `O1`–`O7` stay 1.
- **Multi-channel order:** `Mask`=8'hA4, `Dwell`=1 → `Select` sequence 2, 5, 7. Each channel has exactly one `Enable`-high cycle. `Done` in cycle 1+3·3+1 relative to Start. `Select` never changes while `Enable`=1.
- **Empty mask and zero dwell:**
  - `Mask`=0 → `Done` one cycle after Start, `Enable` never high.
  - `Mask`=8'h80 with `Dwell`=0 → one `Enable` cycle on `Select`=7.
- **Busy interactions:** `Start` re-asserted and `Mask` changed mid-scan → no restart, original sequence completes. `Start` held high through `Done` → second scan begins one cycle after IDLE.
- **Reset mid-strobe:** assert `Reset_N`=0 while `Enable`=1 → `Enable`, `Busy`, `Select` go to 0 and `DOut` to all-ones without waiting for a clock edge, and no `Done` pulse. A normal scan works after release.
- **Repeat build:** with `DEMUX_SCANNER_REPEAT_EN`, `Mask`=8'h03 → `Select` 0,1,0,1,… . `Stop` pulsed during channel 1's STROBE → finishes channel 1, then `Done`, then IDLE.

Source files
------------

// File: rtl/demux_scanner.sv
// Purpose : sequences Select/Enable/DOut of a 1-to-8 demux over the channels of a captured mask.
// Latency : first SETUP one cycle after Start; D+2 cycles per channel; Done one cycle after last HOLD.
// Backpres: none; Start is only sampled in IDLE and is dropped (not queued) while Busy.
// Option  : DEMUX_SCANNER_REPEAT_EN adds the Stop input and continuous rescanning.
module demux_scanner #(
  parameter int DataWidth  = 1,
  parameter int DwellWidth = 8
) (
  input  logic                  Clock,
  input  logic                  Reset_N,
  input  logic                  Start,
  input  logic [7:0]            Mask,
  input  logic [DwellWidth-1:0] Dwell,
  input  logic [DataWidth-1:0]  DIn,
`ifdef DEMUX_SCANNER_REPEAT_EN
  input  logic                  Stop,
`endif
  output logic [2:0]            Select,
  output logic                  Enable,
  output logic [DataWidth-1:0]  DOut,
  output logic                  Busy,
  output logic                  Done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t                state;
  logic [7:0]            work_mask;   // channels still to visit in this pass
  logic [DwellWidth-1:0] dwell_m1;    // captured strobe length minus one
  logic [DwellWidth-1:0] dwell_cnt;   // strobe down-counter

`ifdef DEMUX_SCANNER_REPEAT_EN
  logic [7:0]            cap_mask;    // original mask, reloaded at the end of each pass
  logic                  stop_flag;   // sticky stop request
  logic                  stop_hit;
  logic [2:0]            reload_sel;
`endif

  logic [7:0]            rem_mask;    // working mask with the current channel removed
  logic [2:0]            start_sel;
  logic [2:0]            next_sel;
  logic [DwellWidth-1:0] dwell_in_m1;

  // Index of the lowest set bit; callers only use it on a non-zero mask.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        r = 3'(i);
      end
    end
    return r;
  endfunction

  // Next-channel selection and dwell normalisation (a zero dwell still strobes once).
  always_comb begin
    rem_mask    = work_mask & ~(8'b1 << Select);
    start_sel   = lowest_set(Mask);
    next_sel    = lowest_set(rem_mask);
    dwell_in_m1 = (Dwell == '0) ? '0 : Dwell - 1'b1;
  end

`ifdef DEMUX_SCANNER_REPEAT_EN
  // A stop seen in the HOLD cycle itself still ends the scan after this channel.
  always_comb begin
    stop_hit   = stop_flag | Stop;
    reload_sel = lowest_set(cap_mask);
  end
`endif

  // Scan state machine; every demux-facing output is a register of this block.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state     <= ST_IDLE;
      work_mask <= '0;
      dwell_m1  <= '0;
      dwell_cnt <= '0;
      Select    <= '0;
      Enable    <= 1'b0;
      DOut      <= '1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
`ifdef DEMUX_SCANNER_REPEAT_EN
      cap_mask  <= '0;
      stop_flag <= 1'b0;
`endif
    end else begin
`ifdef DEMUX_SCANNER_REPEAT_EN
      if (Stop && (state != ST_IDLE)) begin
        stop_flag <= 1'b1;
      end
`endif
      case (state)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            work_mask <= Mask;
            dwell_m1  <= dwell_in_m1;
            DOut      <= DIn;
            Busy      <= 1'b1;
`ifdef DEMUX_SCANNER_REPEAT_EN
            cap_mask  <= Mask;
            stop_flag <= 1'b0;
`endif
            if (Mask != 8'd0) begin
              Select <= start_sel;
              state  <= ST_SETUP;
            end else begin
              Done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end

        ST_SETUP: begin
          // Address has been stable for a cycle; open the strobe.
          Enable    <= 1'b1;
          dwell_cnt <= dwell_m1;
          state     <= ST_STROBE;
        end

        ST_STROBE: begin
          if (dwell_cnt == '0) begin
            Enable <= 1'b0;
            state  <= ST_HOLD;
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end

        ST_HOLD: begin
          work_mask <= rem_mask;
`ifdef DEMUX_SCANNER_REPEAT_EN
          if (stop_hit) begin
            Done  <= 1'b1;
            state <= ST_DONE;
          end else if (rem_mask != 8'd0) begin
            Select <= next_sel;
            state  <= ST_SETUP;
          end else begin
            work_mask <= cap_mask;
            Select    <= reload_sel;
            state     <= ST_SETUP;
          end
`else
          if (rem_mask != 8'd0) begin
            Select <= next_sel;
            state  <= ST_SETUP;
          end else begin
            Done  <= 1'b1;
            state <= ST_DONE;
          end
`endif
        end

        ST_DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          DOut  <= '1;
          state <= ST_IDLE;
        end

        default: begin
          state  <= ST_IDLE;
          Enable <= 1'b0;
          Busy   <= 1'b0;
          Done   <= 1'b0;
          DOut   <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_scanner.sv
// Bench for demux_scanner: randomised scans compared cycle by cycle with a trace model.
// The model lists, per visited channel, one setup, D strobe and one hold cycle.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_demux_scanner;
  localparam int DW = 8;
  localparam int WW = 8;

  logic          Clock = 1'b0;
  logic          Reset_N;
  logic          Start;
  logic [7:0]    Mask;
  logic [WW-1:0] Dwell;
  logic [DW-1:0] DIn;
  logic [2:0]    Select;
  logic          Enable;
  logic [DW-1:0] DOut;
  logic          Busy;
  logic          Done;
`ifdef DEMUX_SCANNER_REPEAT_EN
  logic          Stop;
`endif

  typedef struct packed {
    logic [2:0]    sel;
    logic          en;
    logic          busy;
    logic          done;
    logic [DW-1:0] dout;
  } obs_t;

  obs_t obs;
  obs_t exp_q[$];
  logic [2:0] last_sel;   // model: Select holds its value outside SETUP entry
  int checks = 0;
  int failures = 0;

  assign obs = {Select, Enable, Busy, Done, DOut};

  demux_scanner #(.DataWidth(DW), .DwellWidth(WW)) dut (
    .Clock  (Clock),
    .Reset_N(Reset_N),
    .Start  (Start),
    .Mask   (Mask),
    .Dwell  (Dwell),
    .DIn    (DIn),
`ifdef DEMUX_SCANNER_REPEAT_EN
    .Stop   (Stop),
`endif
    .Select (Select),
    .Enable (Enable),
    .DOut   (DOut),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 Clock = ~Clock;

  function automatic obs_t mk(input logic [2:0] s, input logic e, input logic b,
                              input logic d, input logic [DW-1:0] o);
    return {s, e, b, d, o};
  endfunction

  // Expected per-cycle outputs starting the cycle after the accepting edge.
  task automatic build_expected(input logic [7:0] m, input logic [WW-1:0] dw,
                                input logic [DW-1:0] x, input int passes);
    int d;
    d = (dw == '0) ? 1 : int'(dw);
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      for (int ch = 0; ch < 8; ch++) begin
        if (m[ch]) begin
          exp_q.push_back(mk(3'(ch), 1'b0, 1'b1, 1'b0, x));
          for (int k = 0; k < d; k++) exp_q.push_back(mk(3'(ch), 1'b1, 1'b1, 1'b0, x));
          exp_q.push_back(mk(3'(ch), 1'b0, 1'b1, 1'b0, x));
          last_sel = 3'(ch);
        end
      end
    end
    exp_q.push_back(mk(last_sel, 1'b0, 1'b1, 1'b1, x));
    exp_q.push_back(mk(last_sel, 1'b0, 1'b0, 1'b0, '1));
  endtask

  task automatic drive_start(input logic [7:0] m, input logic [WW-1:0] dw, input logic [DW-1:0] x);
    @(negedge Clock);
    Mask  = m;
    Dwell = dw;
    DIn   = x;
    Start = 1'b1;
  endtask

  task automatic test_reset;
    #2 Reset_N = 1'b0;
    #1;
    checks++;
    if (obs !== mk(3'd0, 1'b0, 1'b0, 1'b0, '1)) begin
      failures++;
      $display("FAIL reset_async got=%h want=%h", obs, mk(3'd0, 1'b0, 1'b0, 1'b0, '1));
    end
    repeat (2) @(negedge Clock);
    checks++;
    if (obs !== mk(3'd0, 1'b0, 1'b0, 1'b0, '1)) begin
      failures++;
      $display("FAIL reset_held got=%h want=%h", obs, mk(3'd0, 1'b0, 1'b0, 1'b0, '1));
    end
    last_sel = 3'd0;
    Reset_N = 1'b1;
  endtask

  task automatic test_single_channel;
    drive_start(8'h01, 8'd3, 8'h00);
    build_expected(8'h01, 8'd3, 8'h00, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == 0) Start = 1'b0;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL single cyc=%0d got{sel,en,busy,done,dout}=%h want=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_multi_order;
    drive_start(8'hA4, 8'd1, 8'h5E);
    build_expected(8'hA4, 8'd1, 8'h5E, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == 0) Start = 1'b0;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL multi_order cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_empty_mask;
    drive_start(8'h00, 8'd4, 8'h99);
    build_expected(8'h00, 8'd4, 8'h99, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == 0) Start = 1'b0;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL empty_mask cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_dwell;
    drive_start(8'h80, 8'd0, 8'hA5);
    build_expected(8'h80, 8'd0, 8'hA5, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == 0) Start = 1'b0;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL zero_dwell cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_dwell_max;
    drive_start(8'h81, 8'd255, 8'h3C);
    build_expected(8'h81, 8'd255, 8'h3C, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == 0) Start = 1'b0;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL dwell_max cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  // Random scans; Start/Mask/Dwell/DIn are scrambled while the scan runs.
  task automatic test_random;
    logic [7:0]    m;
    logic [WW-1:0] dw;
    logic [DW-1:0] x;
    for (int n = 0; n < 25; n++) begin
      m  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      dw = WW'($urandom_range(0, 6));
      x  = DW'($urandom);
      drive_start(m, dw, x);
      build_expected(m, dw, x, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge Clock);
        Mask  = 8'($urandom);
        Dwell = WW'($urandom);
        DIn   = DW'($urandom);
        Start = (i == exp_q.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
        checks++;
        if (obs !== exp_q[i]) begin
          failures++;
          $display("FAIL random scan=%0d mask=%h dwell=%0d cyc=%0d got=%h want=%h",
                   n, m, dw, i, obs, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_busy_interactions;
    drive_start(8'h5A, 8'd2, 8'h77);
    build_expected(8'h5A, 8'd2, 8'h77, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      Start = (i == exp_q.size() - 1) ? 1'b0 : 1'b1;
      Mask  = 8'hFF ^ 8'(i);
      DIn   = 8'h00;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL busy_restart cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  // Start held high through Done: second scan starts the cycle after IDLE.
  task automatic test_back_to_back;
    drive_start(8'h11, 8'd1, 8'h3C);
    build_expected(8'h11, 8'd1, 8'h3C, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == exp_q.size() - 2) begin
        Mask  = 8'h06;
        Dwell = 8'd2;
        DIn   = 8'hC3;
      end
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_first cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
    end
    build_expected(8'h06, 8'd2, 8'hC3, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == 0) Start = 1'b0;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_second cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_strobe;
    drive_start(8'h24, 8'd4, 8'h5A);
    build_expected(8'h24, 8'd4, 8'h5A, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      if (i == 0) Start = 1'b0;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL pre_reset cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
    end
    #2 Reset_N = 1'b0;
    #1;
    last_sel = 3'd0;
    checks++;
    if (obs !== mk(3'd0, 1'b0, 1'b0, 1'b0, '1)) begin
      failures++;
      $display("FAIL mid_reset_async got=%h want=%h", obs, mk(3'd0, 1'b0, 1'b0, 1'b0, '1));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checks++;
      if (obs !== mk(3'd0, 1'b0, 1'b0, 1'b0, '1)) begin
        failures++;
        $display("FAIL mid_reset_held cyc=%0d got=%h want=%h", i, obs, mk(3'd0, 1'b0, 1'b0, 1'b0, '1));
      end
    end
    Reset_N = 1'b1;
    drive_start(8'h42, 8'd2, 8'hE1);
    build_expected(8'h42, 8'd2, 8'hE1, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == 0) Start = 1'b0;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
    end
  endtask

`ifdef DEMUX_SCANNER_REPEAT_EN
  // Mask 0x03, dwell 2: 8 cycles per pass; Stop pulsed in channel 1 strobe of pass 3.
  task automatic test_repeat;
    drive_start(8'h03, 8'd2, 8'h6B);
    build_expected(8'h03, 8'd2, 8'h6B, 3);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == 0) Start = 1'b0;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL repeat cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      end
      Stop = (i == 21) ? 1'b1 : 1'b0;
    end
    Stop = 1'b0;
  endtask
`endif

  initial begin
    Reset_N  = 1'b1;
    Start    = 1'b0;
    Mask     = 8'h00;
    Dwell    = '0;
    DIn      = '0;
    last_sel = 3'd0;
`ifdef DEMUX_SCANNER_REPEAT_EN
    Stop     = 1'b0;
`endif
    test_reset;
`ifdef DEMUX_SCANNER_REPEAT_EN
    test_repeat;
    test_empty_mask;
`else
    test_single_channel;
    test_multi_order;
    test_empty_mask;
    test_zero_dwell;
    test_dwell_max;
    test_random;
    test_busy_interactions;
    test_back_to_back;
    test_reset_mid_strobe;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
